dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind an Enable/Ack handshake with programmable wait states.
// Optional out-of-range detection is enabled by defining DMEM_RESP_OOR_EN.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ReadEnable,
   input  logic        WriteEnable,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic [3:0]  ByteEnable,
   output logic [31:0] ReadData,
   output logic        Ack,
   output logic        Busy,
   output logic        AddrError
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            wr_q;
   logic            oor_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic [31:0]     rdata_q;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            req;
   logic            accept;
   logic            enter_ack;
   logic            oor_in;
   logic            eff_wr;
   logic            eff_oor;
   logic [AW-1:0]   eff_idx;
   logic [31:0]     eff_wdata;
   logic [3:0]      eff_be;
   logic            unused_addr;

   assign req    = ReadEnable | WriteEnable;
   assign accept = (state_q == IDLE) && req;

`ifdef DMEM_RESP_OOR_EN
   assign oor_in = ({2'b00, Address[31:2]} >= 32'(DEPTH_WORDS));
`else
   assign oor_in = 1'b0;
`endif

   // Upper address bits only matter for range checking; byte offset is never used.
   assign unused_addr = ^{Address[31:AW+2], Address[1:0]};

   // With LATENCY=0 the array access happens on the acceptance edge itself,
   // so the access fields come straight from the ports in IDLE.
   always_comb begin
      if (state_q == IDLE) begin
         eff_wr    = WriteEnable;
         eff_oor   = oor_in;
         eff_idx   = Address[AW+1:2];
         eff_wdata = WriteData;
         eff_be    = ByteEnable;
      end else begin
         eff_wr    = wr_q;
         eff_oor   = oor_q;
         eff_idx   = idx_q;
         eff_wdata = wdata_q;
         eff_be    = be_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (LATENCY == 0) begin
                  state_d = ACK;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY);
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               state_d = ACK;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_ack = (state_d == ACK);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= WriteEnable;
            oor_q   <= oor_in;
            idx_q   <= Address[AW+1:2];
            wdata_q <= WriteData;
            be_q    <= ByteEnable;
         end
         // Pre-write word is captured, so a combined read/write returns old data.
         if (enter_ack) rdata_q <= eff_oor ? 32'hDEAD_BEEF : mem[eff_idx];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && enter_ack && eff_wr && !eff_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (eff_be[i]) mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
         end
      end
   end

`ifdef DMEM_RESP_OOR_EN
   logic err_q;

   always_ff @(posedge CLK) begin
      if (RST)            err_q <= 1'b0;
      else if (enter_ack) err_q <= eff_oor;
   end

   assign AddrError = Ack & err_q;
`else
   assign AddrError = 1'b0;
`endif

   assign Ack      = (state_q == ACK);
   assign Busy     = (state_q != IDLE);
   assign ReadData = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 0 and 3.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        re   [3];
   logic        we   [3];
   logic [31:0] addr [3];
   logic [31:0] wd   [3];
   logic [3:0]  be   [3];
   logic [31:0] rd   [3];
   logic        ack  [3];
   logic        busy [3];
   logic        err  [3];

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
      .CLK(clk), .RST(rst), .ReadEnable(re[0]), .WriteEnable(we[0]), .Address(addr[0]),
      .WriteData(wd[0]), .ByteEnable(be[0]), .ReadData(rd[0]), .Ack(ack[0]), .Busy(busy[0]),
      .AddrError(err[0]));
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_l0 (
      .CLK(clk), .RST(rst), .ReadEnable(re[1]), .WriteEnable(we[1]), .Address(addr[1]),
      .WriteData(wd[1]), .ByteEnable(be[1]), .ReadData(rd[1]), .Ack(ack[1]), .Busy(busy[1]),
      .AddrError(err[1]));
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
      .CLK(clk), .RST(rst), .ReadEnable(re[2]), .WriteEnable(we[2]), .Address(addr[2]),
      .WriteData(wd[2]), .ByteEnable(be[2]), .ReadData(rd[2]), .Ack(ack[2]), .Busy(busy[2]),
      .AddrError(err[2]));

   typedef struct {
      int          sel;
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_n;
   } vec_t;

   vec_t vt[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; n counts negedges from request until Ack is seen.
   task automatic access(input int s, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         output logic [31:0] rdo, output logic erro, output int n);
      re[s] = r; we[s] = w; addr[s] = a; wd[s] = d; be[s] = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!ack[s]) chk("busy_wait", busy[s], 1'b1);
      end while (!ack[s] && n < 40);
      rdo = rd[s];
      erro = err[s];
      re[s] = 1'b0; we[s] = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", ack[s], 1'b0);
      chk("busy_done", busy[s], 1'b1);
      chk("rd_held", rd[s], rdo);
      @(negedge clk);
      chk("busy_idle", busy[s], 1'b0);
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          n, gap;

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         re[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wd[i] = 32'd0; be[i] = 4'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_rd", rd[i], 32'd0);
         chk("rst_ack", ack[i], 1'b0);
         chk("rst_busy", busy[i], 1'b0);
         chk("rst_err", err[i], 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);

      // sel: 0 = LATENCY 2 (n=3), 1 = LATENCY 0 (n=1), 2 = LATENCY 3 (n=4)
      vt.push_back('{0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0, 3});
      vt.push_back('{0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 1'b0, 3});
      vt.push_back('{1, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b0, 1});
      vt.push_back('{1, 1'b0, 1'b1, 32'h20, 32'h0000_00AB, 4'h1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1});
      vt.push_back('{1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFAB, 1'b0, 1});
      vt.push_back('{1, 1'b0, 1'b1, 32'h24, 32'h1111_1111, 4'hF, 1'b0, 32'h0, 1'b0, 1});
      vt.push_back('{1, 1'b1, 1'b1, 32'h24, 32'h5555_5555, 4'hF, 1'b1, 32'h1111_1111, 1'b0, 1});
      vt.push_back('{1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 32'h5555_5555, 1'b0, 1});
      vt.push_back('{2, 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 4});
      vt.push_back('{2, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 4});
      vt.push_back('{2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 4});
      vt.push_back('{0, 1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0, 1'b0, 3});
`ifdef DMEM_RESP_OOR_EN
      vt.push_back('{0, 1'b0, 1'b1, 32'h1000, 32'h0102_0304, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1, 3});
      vt.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA5A5_A5A5, 1'b0, 3});
`else
      vt.push_back('{0, 1'b0, 1'b1, 32'h1000, 32'h0102_0304, 4'hF, 1'b1, 32'hA5A5_A5A5, 1'b0, 3});
      vt.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0102_0304, 1'b0, 3});
`endif
      vt.push_back('{0, 1'b0, 1'b1, 32'h12, 32'hAABB_0000, 4'hC, 1'b1, 32'h1234_5678, 1'b0, 3});
      vt.push_back('{0, 1'b1, 1'b0, 32'h11, 32'h0, 4'h0, 1'b1, 32'hAABB_5678, 1'b0, 3});

      for (int i = 0; i < vt.size(); i++) begin
         access(vt[i].sel, vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].b, r, e, n);
         chk($sformatf("v%0d_latency", i), n, vt[i].exp_n);
         chk($sformatf("v%0d_err", i), e, vt[i].exp_err);
         if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), r, vt[i].exp_rd);
      end

      // Read held high through Ack: DONE ignores it, IDLE accepts it, then 2 wait states.
      re[0] = 1'b1; addr[0] = 32'h10;
      n = 0;
      do begin @(negedge clk); n++; end while (!ack[0] && n < 40);
      chk("hold_first_latency", n, 3);
      gap = 0;
      do begin @(negedge clk); gap++; end while (!ack[0] && gap < 40);
      chk("hold_ack_gap", gap, 5);
      chk("hold_rdata", rd[0], 32'hAABB_5678);
      re[0] = 1'b0;
      repeat (2) @(negedge clk);

      // Abort: read on LATENCY 3 dropped in the second WAIT cycle.
      re[2] = 1'b1; addr[2] = 32'h40;
      repeat (2) @(negedge clk);
      chk("abort_busy_wait", busy[2], 1'b1);
      re[2] = 1'b0;
      @(negedge clk);
      chk("abort_busy_fall", busy[2], 1'b0);
      n = 0;
      repeat (6) begin @(negedge clk); if (ack[2]) n++; end
      chk("abort_no_ack", n, 0);
      access(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, r, e, n);
      chk("after_abort_latency", n, 4);
      chk("after_abort_rdata", r, 32'hCAFE_F00D);

      // Enables swapped after acceptance: operation stays a read.
      re[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40; be[2] = 4'hF;
      @(negedge clk);
      re[2] = 1'b0; we[2] = 1'b1; wd[2] = 32'h0;
      n = 1;
      while (!ack[2] && n < 40) begin @(negedge clk); n++; end
      chk("swap_latency", n, 4);
      chk("swap_rdata", rd[2], 32'hCAFE_F00D);
      we[2] = 1'b0;
      repeat (2) @(negedge clk);
      access(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, r, e, n);
      chk("swap_mem_intact", r, 32'hCAFE_F00D);

      // Reset in WAIT (d=1) and on the ACK-entry edge (d=2) of a write.
      for (int d = 1; d <= 2; d++) begin
         we[0] = 1'b1; addr[0] = 32'h10; wd[0] = 32'hDEAD_DEAD; be[0] = 4'hF;
         repeat (d) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0; we[0] = 1'b0;
         chk($sformatf("rst%0d_rd", d), rd[0], 32'd0);
         chk($sformatf("rst%0d_ack", d), ack[0], 1'b0);
         chk($sformatf("rst%0d_busy", d), busy[0], 1'b0);
         chk($sformatf("rst%0d_err", d), err[0], 1'b0);
         @(negedge clk);
         access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, r, e, n);
         chk($sformatf("rst%0d_word_intact", d), r, 32'hAABB_5678);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
